// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcodes, instruction field positions and the
// fetch FSM state encoding used by instr_fetch.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_BIT = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, decoder
// redirect input and the decoded-instruction handoff.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      dec_op;
  logic [2:0]      dec_funct3;
  logic            dec_funct7;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_target, dec_ready,
    output dec_valid, dec_instr, dec_pc, dec_op, dec_funct3, dec_funct7,
    output fetch_fault
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_target, dec_ready,
    input  dec_valid, dec_instr, dec_pc, dec_op, dec_funct3, dec_funct7,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instr} entries with flush; DEPTH must be a power
// of two so the pointers wrap naturally.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage, pointers and occupancy; flush drops every entry at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: credit-limited word requests, buffered responses,
// redirect flush with in-flight drop counting. Optional misaligned-redirect
// trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] fpc_r, rpc_r, target_s;
  logic [CW-1:0]   outstanding_r, outstanding_nxt_s;
  logic [CW-1:0]   drop_cnt_r, drop_nxt_s;
  logic [CW-1:0]   buf_count_s;
  logic            buf_full_s, buf_empty_s;
  logic            fetching_s, credit_ok_s, req_valid_s, req_fire_s;
  logic            redir_s, misalign_s, rsp_keep_s, flush_s;
  logic [2*XLEN-1:0] head_s;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign target_s   = bus.redirect_target;
  assign misalign_s = (bus.redirect_target[1:0] != 2'b00);
`else
  assign target_s   = bus.redirect_target & ~32'h0000_0003;
  assign misalign_s = 1'b0;
`endif

  assign fetching_s  = (state_r == FETCH);
  assign credit_ok_s = (({1'b0, outstanding_r} + {1'b0, buf_count_s}) < (CW+1)'(BUF_DEPTH));
  assign req_valid_s = fetching_s & credit_ok_s;
  assign req_fire_s  = req_valid_s & bus.imem_req_ready;
  assign redir_s     = fetching_s & bus.redirect;
  // A response is dropped when it races a redirect or belongs to the old path
  assign rsp_keep_s  = bus.imem_rsp_valid & fetching_s & ~redir_s & (drop_cnt_r == CW'(0));
  assign flush_s     = redir_s | (state_r == HALT);
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(bus.imem_rsp_valid);

  // Next-state selection for the fetch FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:  state_nxt_s = FETCH;
      FETCH: begin
        if (redir_s && misalign_s) state_nxt_s = HALT;
        else                       state_nxt_s = FETCH;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      HALT:  state_nxt_s = HALT;
`else
      HALT:  state_nxt_s = IDLE;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // Drop counter: reload with post-cycle outstanding on redirect, else count down
  always_comb begin
    drop_nxt_s = drop_cnt_r;
    if (redir_s) drop_nxt_s = outstanding_nxt_s;
    else if (bus.imem_rsp_valid && (drop_cnt_r != CW'(0))) drop_nxt_s = drop_cnt_r - CW'(1);
    else drop_nxt_s = drop_cnt_r;
  end

  // FSM state, PC counters and credit/drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      fpc_r         <= RESET_PC;
      rpc_r         <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      state_r       <= state_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= drop_nxt_s;
      if (redir_s)         fpc_r <= target_s;
      else if (req_fire_s) fpc_r <= fpc_r + PC_STEP;
      if (redir_s)         rpc_r <= target_s;
      else if (rsp_keep_s) rpc_r <= rpc_r + PC_STEP;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_r;
  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)                     fault_r <= 1'b0;
    else if (redir_s && misalign_s) fault_r <= 1'b1;
  end
  assign bus.fetch_fault = fault_r;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(2*XLEN)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep_s & ~buf_full_s),
    .pop   (bus.dec_ready),
    .flush (flush_s),
    .wdata ({rpc_r, bus.imem_rsp_data}),
    .rdata (head_s),
    .full  (buf_full_s),
    .empty (buf_empty_s),
    .count (buf_count_s)
  );

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fpc_r;
  assign bus.dec_valid      = ~buf_empty_s;
  assign bus.dec_pc         = head_s[2*XLEN-1:XLEN];
  assign bus.dec_instr      = head_s[XLEN-1:0];
  assign bus.dec_op         = head_s[OP_MSB:OP_LSB];
  assign bus.dec_funct3     = head_s[FUNCT3_MSB:FUNCT3_LSB];
  assign bus.dec_funct7     = head_s[FUNCT7_BIT];
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model with variable latency,
// expected decode PCs queued by the stimulus, popped by a decode monitor.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 1;
  logic [31:0] exp_q[$];

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h00A2_8293;
    return {a[11:0], a[31:12]} ^ 32'h4000_5033;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d decodes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  bus.imem_req_addr, 32'h0000_0000);
    chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
    chk({tag, "_dec_instr"}, bus.dec_instr, 32'd0);
    chk({tag, "_dec_pc"},    bus.dec_pc, 32'd0);
    chk({tag, "_dec_fields"}, {20'd0, bus.dec_funct7, bus.dec_funct3, 1'b0, bus.dec_op}, 32'd0);
    chk({tag, "_fault"},     32'(bus.fetch_fault), 32'd0);
  endtask

  // Memory model: in-order responses 'lat' cycles after each handshake
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instr_at(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
      end
    end
  end

  // Decode monitor: compare each handshaken instruction with the scoreboard
  initial begin
    logic [31:0] e, ei;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dec_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_decode: got pc %h, expected none", bus.dec_pc);
        end else begin
          e  = exp_q.pop_front();
          ei = instr_at(e);
          chk("dec_pc", bus.dec_pc, e);
          chk("dec_instr", bus.dec_instr, ei);
          chk("dec_fields", {20'd0, bus.dec_funct7, bus.dec_funct3, 1'b0, bus.dec_op},
              {20'd0, ei[30], ei[14:12], 1'b0, ei[6:0]});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fires;
    rst_n = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'd0;
    bus.dec_ready       = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_vals("rst");

    // Release reset with decoder stalled: IDLE cycle, then exactly two requests
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0000_0000);
    fires = 32'(bus.imem_req_valid & bus.imem_req_ready);
    for (int i = 1; i < 10; i++) begin
      tick();
      @(negedge clk);
      fires += 32'(bus.imem_req_valid & bus.imem_req_ready);
    end
    chk("stall_req_count", 32'(fires), 32'd2);
    chk("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
    chk("first_dec_pc", bus.dec_pc, 32'h0000_0000);
    chk("first_dec_instr", bus.dec_instr, 32'h00A2_8293);
    chk("first_dec_op", 32'(bus.dec_op), 32'h13);
    chk("first_dec_f3f7", {28'd0, bus.dec_funct7, bus.dec_funct3}, 32'd0);

    // Drain in order, then stall: buffer settles holding 0x30, 0x34
    push_seq(32'h0, 12);
    tick(); bus.dec_ready = 1'b1;
    drain("seq0");
    bus.dec_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("full_dec_pc", bus.dec_pc, 32'h0000_0030);
    chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);

    // Redirect to 0x200, let two slow requests go out, then redirect to 0x100
    tick(); lat = 4; bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0200;
    tick(); bus.redirect = 1'b0;
    @(negedge clk);
    chk("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    tick(); bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0100;
    @(negedge clk);
    chk("two_out_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("two_out_req_addr", bus.imem_req_addr, 32'h0000_0208);
    tick(); bus.redirect = 1'b0; lat = 1;
    @(negedge clk);
    chk("redir_req_addr", bus.imem_req_addr, 32'h0000_0100);
    push_seq(32'h100, 8);
    tick(); bus.dec_ready = 1'b1;
    drain("redir_drop2");
    bus.dec_ready = 1'b0;
    repeat (8) tick();

    // Redirect coinciding with a response and a decode handshake
    push_seq(32'h120, 2);
    tick(); bus.dec_ready = 1'b1;
    tick(); bus.dec_ready = 1'b0;
    @(negedge clk);
    chk("b1_req_addr", bus.imem_req_addr, 32'h0000_0128);
    tick(); bus.dec_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0300;
    @(negedge clk);
    chk("b2_dec_pc", bus.dec_pc, 32'h0000_0124);
    tick(); bus.dec_ready = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);
    chk("b3_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("b3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("b3_req_addr", bus.imem_req_addr, 32'h0000_0300);
    push_seq(32'h300, 6);
    tick(); bus.dec_ready = 1'b1;
    drain("redir_rsp_dec");
    bus.dec_ready = 1'b0;
    repeat (6) tick();

    // Address wrap past 0xFFFF_FFFC
    tick(); bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFF8;
    tick(); bus.redirect = 1'b0;
    push_seq(32'hFFFF_FFF8, 5);
    bus.dec_ready = 1'b1;
    drain("wrap");
    bus.dec_ready = 1'b0;
    repeat (6) tick();

    // Misaligned redirect
    tick(); bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0102;
    tick(); bus.redirect = 1'b0;
    @(negedge clk);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("trap_fault", 32'(bus.fetch_fault), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("halt_dec_valid", 32'(bus.dec_valid), 32'd0);
      tick();
      @(negedge clk);
    end
`else
    chk("misalign_fault", 32'(bus.fetch_fault), 32'd0);
    chk("misalign_req_addr", bus.imem_req_addr, 32'h0000_0100);
    push_seq(32'h100, 3);
    tick(); bus.dec_ready = 1'b1;
    drain("misalign");
    bus.dec_ready = 1'b0;
    repeat (6) tick();
`endif

    // Reset mid-operation with competing inputs active
    tick(); rst_n = 1'b0; bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0500;
    bus.dec_ready = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk);
    check_reset_vals("midrst");
    tick(); rst_n = 1'b1; bus.redirect = 1'b0;
    push_seq(32'h0, 4);
    drain("after_reset");
    bus.dec_ready = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RV32 single-issue core. It issues word reads to instruction memory and buffers the returned instructions. It presents them, with pre-split opcode/funct fields, to the control/decode unit. It also consumes the decoder's `PCSrc` redirect and branch/jump target, flushing wrong-path instructions.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: instruction buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request; handshake = valid & ready.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response valid; in order, no back-pressure.
- `imem_rsp_data`  in  32  instruction word.
- `redirect`  in  1  `PCSrc` from decoder; taken branch/jump.
- `redirect_target`  in  32  new PC, sampled when `redirect`=1.
- `dec_valid`  out  1  instruction available to decoder.
- `dec_ready`  in  1  decoder accepts; handshake = valid & ready.
- `dec_instr`  out  32  instruction word.
- `dec_pc`  out  32  its address.
- `dec_op`  out  7  `instr[6:0]`.
- `dec_funct3`  out  3  `instr[14:12]`.
- `dec_funct7`  out  1  `instr[30]`.
- `fetch_fault`  out  1  misaligned redirect (only with macro; tied 0 otherwise).

## Operation
- FSM states:
  - IDLE: entered on reset; goes to FETCH on the next cycle.
  - FETCH: normal operation.
  - HALT: only with macro; exit only via reset.
- Fetch PC register `fpc`:
  - `imem_req_addr` = `fpc`.
  - On request handshake, `fpc` += 4, wrapping mod 2^32.
- Credit rule:
  - `imem_req_valid` = FETCH & (outstanding + buffered < BUF_DEPTH).
  - Every accepted response therefore has a free buffer slot.
- Each buffer entry holds {pc, instr}. The pc is a second counter `rpc`, advanced +4 per accepted non-dropped response.
- `dec_*` outputs show the head entry; `dec_valid` = buffer non-empty.
- Redirect (in FETCH):
  - Buffer flushed.
  - `fpc` ← target; `rpc` ← target.
  - `drop_cnt` ← outstanding requests, including any handshaken this cycle.
  - While `drop_cnt` > 0, each response decrements it and is discarded.
- Counters `outstanding` and `drop_cnt` are clog2(BUF_DEPTH)+1 bits wide; they never exceed BUF_DEPTH.
- Memory must be reset together with this block. No in-flight responses survive reset.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `dec_valid`=0; `dec_instr`, `dec_pc`, `dec_op`, `dec_funct3`, `dec_funct7` all 0.
  - `fetch_fault`=0.
  - Counters and buffer empty.
- First `imem_req_valid`=1 is 1 cycle after `rst_n` rises (IDLE→FETCH).
- Response accepted in cycle N → `dec_valid`=1 in cycle N+1 (registered buffer).
- Full buffer: `dec_valid` stays high while `dec_ready`=0; no new requests issue.
- Empty buffer with a response arriving: no bypass; 1-cycle latency still applies.
- Redirect in the same cycle as a request handshake: that request is counted into `drop_cnt`. The next cycle's `imem_req_addr` = target.
- Redirect in the same cycle as a response: response dropped, and not counted in `drop_cnt`.
- Redirect in the same cycle as a decode handshake: head consumed, remainder flushed. `dec_valid`=0 next cycle.
- Reset asserted mid-operation: all state cleared on that edge, regardless of other inputs.

## Configuration
- Macro `IFETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_target[1:0]` != 0 sets `fetch_fault`=1 the next cycle and enters HALT.
  - In HALT: no requests, buffer flushed, `dec_valid`=0.
- Undefined:
  - `redirect_target[1:0]` is forced to 0.
  - No HALT state; `fetch_fault` is a constant 0.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams (R_TYPE, I_TYPE, S_TYPE, LOAD, BRANCH, JALR, JAL)
  - XLEN=32
  - field bit-position constants
  - fetch FSM state enum.
- Sub-module `fetch_buffer`: synchronous FIFO of {pc, instr}, BUF_DEPTH deep, with push/pop/flush and full/empty/count outputs.
- Top-level logic: FSM, PC counters, credit and drop counters.

## Test plan
- Reset, `imem_req_ready`=1, 1-cycle memory latency, `dec_ready`=1 → addresses 0,4,8,… issued. Instruction 0x00A28293 shows `dec_op`=0x13, `dec_funct3`=0, `dec_funct7`=0, `dec_pc`=0.
- `dec_ready`=0 for 10 cycles → exactly 2 requests issued, `dec_valid` held, no further requests. On release, instructions drain in order.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped; next `dec_pc`=0x100.
- Redirect in the same cycle as a response and a decode handshake → handshaken instruction consumed, response discarded; first new `dec_pc` = target.
- `fpc`=0xFFFF_FFFC → next request address 0x0000_0000.
- With `IFETCH_MISALIGN_TRAP_EN`: redirect to 0x102 → `fetch_fault`=1 next cycle, `imem_req_valid`=0 until reset. Without the macro: fetch from 0x100.
